// File: rtl/shift_len_ctrl_pkg.sv
// shift_len_pkg: shared width, state encoding and wrap/saturate step for shift_len_ctrl (SHIFT_LEN_SAT_EN selects saturation)
package shift_len_pkg;
  localparam int MAX_LEN_DEF = 15;
  localparam int LEN_W = $clog2(MAX_LEN_DEF + 1);
  localparam logic [1:0] MAN_IDLE = 2'b00;
  localparam logic [1:0] MAN_PEND = 2'b01;
  localparam logic [1:0] SWP_WAIT = 2'b10;
  localparam logic [1:0] SWP_PEND = 2'b11;
  function automatic logic [LEN_W-1:0] step_len(input logic [LEN_W-1:0] v, input logic up, input logic [LEN_W-1:0] mx);
`ifdef SHIFT_LEN_SAT_EN
    return up ? ((v == mx) ? mx : v + 1'b1) : ((v == '0) ? '0 : v - 1'b1);
`else
    return up ? ((v == mx) ? '0 : v + 1'b1) : ((v == '0) ? mx : v - 1'b1);
`endif
  endfunction
endpackage

// File: rtl/shift_len_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse on accepted rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 120000
) (
  input  logic ext_clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0] sync;
  logic db, acc;
  logic [CW-1:0] cnt;
  assign acc = (sync[1] != db) && (cnt == CW'(DEBOUNCE_CYC - 1));
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      sync  <= '0;
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      cnt   <= (sync[1] != db && !acc) ? cnt + 1'b1 : '0;
      db    <= acc ? sync[1] : db;
      press <= acc && sync[1];
    end
  end
endmodule

// File: rtl/shift_len_ctrl.sv
// shift_len_ctrl: button/sweep delay-length controller committing at frame_sync or timeout (SHIFT_LEN_SAT_EN: saturate and bounce)
module shift_len_ctrl
  import shift_len_pkg::*;
#(
  parameter int MAX_LEN      = MAX_LEN_DEF,
  parameter int DEBOUNCE_CYC = 120000,
  parameter int SWEEP_CYC    = 12000000,
  parameter int TIMEOUT_CYC  = 1200000
) (
  input  logic             ext_clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             btn_mode,
  input  logic             frame_sync,
  output logic [LEN_W-1:0] len,
  output logic             len_upd,
  output logic             pending,
  output logic             sweep_mode,
  output logic             timeout_pulse
);
  localparam int SW_W = $clog2(SWEEP_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_W-1:0] MX = LEN_W'(MAX_LEN);
  logic up_p, dn_p, mode_p;
  logic [1:0] st, st_n;
  logic [LEN_W-1:0] target, target_n;
  logic [SW_W-1:0] scnt;
  logic [TO_W-1:0] tcnt;
  logic tmo, commit, tick, mode_n, pend_n, sw_up;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up   (.ext_clk, .rst, .btn(btn_up),   .press(up_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn   (.ext_clk, .rst, .btn(btn_dn),   .press(dn_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (.ext_clk, .rst, .btn(btn_mode), .press(mode_p));
  assign sweep_mode = st[1];
  assign pending    = st[0];
`ifdef SHIFT_LEN_SAT_EN
  logic dir;
  assign sw_up = (target == MX) ? 1'b0 : (target == '0) ? 1'b1 : dir;
  always_ff @(posedge ext_clk) begin
    if (rst) dir <= 1'b1;
    else if (tick) dir <= sw_up;
  end
`else
  assign sw_up = 1'b1;
`endif
  always_comb begin
    tmo      = pending && (tcnt == TO_W'(TIMEOUT_CYC - 1));
    commit   = frame_sync || tmo;
    tick     = sweep_mode && (scnt == SW_W'(SWEEP_CYC - 1));
    mode_n   = sweep_mode ^ mode_p;
    target_n = sweep_mode ? (tick ? step_len(target, sw_up, MX) : target)
                          : ((up_p != dn_p) ? step_len(target, up_p, MX) : target);
    pend_n   = target_n != (commit ? target : len);
    st_n     = mode_n ? (pend_n ? SWP_PEND : SWP_WAIT) : (pend_n ? MAN_PEND : MAN_IDLE);
  end
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      st            <= MAN_IDLE;
      target        <= '0;
      len           <= '0;
      len_upd       <= 1'b0;
      timeout_pulse <= 1'b0;
      scnt          <= '0;
      tcnt          <= '0;
    end else begin
      st            <= st_n;
      target        <= target_n;
      len           <= commit ? target : len;
      len_upd       <= commit && (target != len);
      timeout_pulse <= tmo;
      scnt          <= (!sweep_mode || tick) ? '0 : scnt + 1'b1;
      tcnt          <= (commit || !pending) ? '0 : tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_len_ctrl.sv
// tb_shift_len_ctrl: scoreboard bench for shift_len_ctrl with short debounce/sweep/timeout periods
module tb_shift_len_ctrl;
  logic ext_clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_dn = 1'b0, btn_mode = 1'b0, frame_sync = 1'b0;
  logic [3:0] len;
  logic len_upd, pending, sweep_mode, timeout_pulse;
  int n_tests = 0;
  int n_fail = 0;
  int upd_cnt = 0;
  logic [3:0] exp_q[$];
  shift_len_ctrl #(.MAX_LEN(15), .DEBOUNCE_CYC(4), .SWEEP_CYC(20), .TIMEOUT_CYC(50)) dut (
    .ext_clk(ext_clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
    .frame_sync(frame_sync), .len(len), .len_upd(len_upd), .pending(pending),
    .sweep_mode(sweep_mode), .timeout_pulse(timeout_pulse)
  );
  always #5 ext_clk = ~ext_clk;
  always @(negedge ext_clk) begin
    if (!rst && len_upd) begin
      upd_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_upd: len_upd with len=%0d, none expected", len);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (len !== e) begin
          n_fail++;
          $display("FAIL sb_len: got %0d exp %0d", len, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge ext_clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic press(input int b);
    btn_up = (b == 0);
    btn_dn = (b == 1);
    btn_mode = (b == 2);
    cyc(5);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    btn_mode = 1'b0;
    cyc(6);
  endtask
  task automatic frame();
    @(posedge ext_clk);
    #1 frame_sync = 1'b1;
    @(posedge ext_clk);
    #1 frame_sync = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge ext_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected updates still outstanding, exp 0", exp_q.size());
    end
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge ext_clk);
    n_tests++;
    if (len !== 4'd0) begin n_fail++; $display("FAIL rst_len: got %0d exp 0", len); end
    n_tests++;
    if (len_upd !== 1'b0) begin n_fail++; $display("FAIL rst_upd: got %b exp 0", len_upd); end
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b exp 0", pending); end
    n_tests++;
    if (sweep_mode !== 1'b0) begin n_fail++; $display("FAIL rst_sweep: got %b exp 0", sweep_mode); end
    n_tests++;
    if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b exp 0", timeout_pulse); end
  endtask
  task automatic test_up3();
    int u0;
    do_reset();
    press(0);
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL up3_pending: got %b exp 1", pending); end
    press(0);
    press(0);
    n_tests++;
    if (len !== 4'd0) begin n_fail++; $display("FAIL up3_len_hold: got %0d exp 0", len); end
    u0 = upd_cnt;
    exp_q.push_back(4'd3);
    frame();
    drain();
    n_tests++;
    if (len !== 4'd3) begin n_fail++; $display("FAIL up3_len: got %0d exp 3", len); end
    n_tests++;
    if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL up3_upd_count: got %0d exp 1", upd_cnt - u0); end
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL up3_pending_clr: got %b exp 0", pending); end
  endtask
  task automatic test_wrap();
    do_reset();
    press(1);
`ifdef SHIFT_LEN_SAT_EN
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL wrap_pending: got %b exp 0", pending); end
    frame();
    cyc(3);
    n_tests++;
    if (len !== 4'd0) begin n_fail++; $display("FAIL wrap_len: got %0d exp 0", len); end
`else
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL wrap_pending: got %b exp 1", pending); end
    exp_q.push_back(4'd15);
    frame();
    drain();
    n_tests++;
    if (len !== 4'd15) begin n_fail++; $display("FAIL wrap_len: got %0d exp 15", len); end
`endif
  endtask
  task automatic test_glitch();
    do_reset();
    btn_up = 1'b1;
    btn_dn = 1'b1;
    cyc(2);
    btn_dn = 1'b0;
    cyc(3);
    btn_up = 1'b0;
    cyc(6);
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL glitch_pending: got %b exp 1", pending); end
    exp_q.push_back(4'd1);
    frame();
    drain();
    n_tests++;
    if (len !== 4'd1) begin n_fail++; $display("FAIL glitch_len: got %0d exp 1", len); end
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    exp_q.push_back(4'd1);
    btn_up = 1'b1;
    n = 0;
    do begin @(negedge ext_clk); n++; end while (!pending && n < 20);
    n = 0;
    do begin @(negedge ext_clk); n++; end while (!timeout_pulse && n < 100);
    n_tests++;
    if (n !== 50) begin n_fail++; $display("FAIL tmo_cycles: got %0d exp 50", n); end
    n_tests++;
    if (len_upd !== 1'b1) begin n_fail++; $display("FAIL tmo_upd: got %b exp 1", len_upd); end
    n_tests++;
    if (len !== 4'd1) begin n_fail++; $display("FAIL tmo_len: got %0d exp 1", len); end
    @(negedge ext_clk);
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL tmo_pending: got %b exp 0", pending); end
    n_tests++;
    if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b exp 0", timeout_pulse); end
    btn_up = 1'b0;
    cyc(8);
  endtask
  task automatic test_sweep();
    int n;
    do_reset();
    btn_mode = 1'b1;
    n = 0;
    do begin @(negedge ext_clk); n++; end while (!sweep_mode && n < 20);
    n_tests++;
    if (sweep_mode !== 1'b1) begin n_fail++; $display("FAIL sweep_mode: got %b exp 1", sweep_mode); end
    n = 0;
    do begin @(negedge ext_clk); n++; end while (!pending && n < 40);
    n_tests++;
    if (n !== 20) begin n_fail++; $display("FAIL sweep_period: got %0d exp 20", n); end
    exp_q.push_back(4'd1);
    frame();
    drain();
    n_tests++;
    if (len !== 4'd1) begin n_fail++; $display("FAIL sweep_len: got %0d exp 1", len); end
    btn_mode = 1'b0;
    press(0);
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL sweep_up_ignored: pending got %b exp 0", pending); end
    n_tests++;
    if (sweep_mode !== 1'b1) begin n_fail++; $display("FAIL sweep_hold: got %b exp 1", sweep_mode); end
  endtask
  task automatic test_reset_pending();
    int u0;
    do_reset();
    repeat (4) press(0);
    exp_q.push_back(4'd4);
    frame();
    drain();
    repeat (3) press(0);
    n_tests++;
    if (pending !== 1'b1 || len !== 4'd4) begin
      n_fail++;
      $display("FAIL rp_pre: got pending=%b len=%0d exp pending=1 len=4", pending, len);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge ext_clk);
    n_tests++;
    if (len !== 4'd0) begin n_fail++; $display("FAIL rp_len: got %0d exp 0", len); end
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL rp_pending: got %b exp 0", pending); end
    u0 = upd_cnt;
    frame();
    cyc(5);
    n_tests++;
    if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL rp_no_upd: got %0d updates exp 0", upd_cnt - u0); end
    press(0);
    exp_q.push_back(4'd1);
    frame();
    drain();
    n_tests++;
    if (len !== 4'd1) begin n_fail++; $display("FAIL rp_target_cleared: got %0d exp 1", len); end
  endtask
  initial begin
    test_reset();
    test_up3();
    test_wrap();
    test_glitch();
    test_timeout();
    test_sweep();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
